// File: rtl/accum_mult_ram_loader_if.sv
// ---------------------------------------------------------------------------
// accum_mult_ram_loader_if: word stream, RAM load port and status of the loader. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface accum_mult_ram_loader_if #(
  parameter int RAM_D_W = 32
);
  logic               i_start;
  logic               i_val;
  logic               o_rdy;
  logic [RAM_D_W-1:0] i_dat;
  logic [RAM_D_W-1:0] i_csum;
  logic [RAM_D_W-1:0] o_ram_d;
  logic               o_ram_we;
  logic               o_ram_se;
  logic               o_busy;
  logic               o_done;
  logic               o_err;

  modport master (
    output i_start, i_val, i_dat, i_csum,
    input  o_rdy, o_ram_d, o_ram_we, o_ram_se, o_busy, o_done, o_err
  );

  modport slave (
    input  i_start, i_val, i_dat, i_csum,
    output o_rdy, o_ram_d, o_ram_we, o_ram_se, o_busy, o_done, o_err
  );
endinterface

`default_nettype wire

// File: rtl/accum_mult_ram_loader.sv
// ---------------------------------------------------------------------------
// accum_mult_ram_loader: replays a word stream into the accum_mult_mod RAM
// chain; optional checksum under ACCUM_RAM_LOADER_CSUM_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module accum_mult_ram_loader #(
  parameter int RAM_A_W  = 8,
  parameter int RAM_D_W  = 32,
  parameter int NUM_RAMS = 12
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  accum_mult_ram_loader_if.slave   bus
);

  localparam int DEPTH  = 2 ** RAM_A_W;
  localparam int BCNT_W = (NUM_RAMS > 1) ? $clog2(NUM_RAMS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    SELECT = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [RAM_A_W-1:0]  wcnt;
  logic [BCNT_W-1:0]   bcnt;
  logic [RAM_D_W-1:0]  ram_d;
  logic                ram_we;
  logic                ram_se;
  logic                busy;
  logic                done;
  logic                err;

  logic last_word;
  logic last_bank;
  logic accept;
  logic start_load;

  assign last_word  = (wcnt == RAM_A_W'(DEPTH - 1));
  assign last_bank  = (bcnt == BCNT_W'(NUM_RAMS - 1));
  assign accept     = (state == WRITE) && bus.i_val;
  assign start_load = ((state == IDLE) || (state == DONE)) && bus.i_start;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (bus.i_start) next_state = WRITE;
      end
      WRITE: begin
        if (bus.i_val && last_word) next_state = SELECT;
      end
      SELECT: begin
        next_state = last_bank ? DONE : WRITE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Strobes default low so each write/select is a single-cycle pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wcnt   <= '0;
      bcnt   <= '0;
      ram_d  <= '0;
      ram_we <= 1'b0;
      ram_se <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      ram_se <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.i_start) begin
            wcnt <= '0;
            bcnt <= '0;
            busy <= 1'b1;
            done <= 1'b0;
          end
        end
        WRITE: begin
          if (bus.i_val) begin
            ram_d  <= bus.i_dat;
            ram_we <= 1'b1;
            if (!last_word) wcnt <= wcnt + RAM_A_W'(1);
          end
        end
        SELECT: begin
          ram_se <= 1'b1;
          wcnt   <= '0;
          if (last_bank) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            bcnt <= bcnt + BCNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ACCUM_RAM_LOADER_CSUM_EN
  logic [RAM_D_W-1:0] csum;

  // csum already holds the final word when SELECT of the last bank is seen.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      csum <= '0;
      err  <= 1'b0;
    end else if (start_load) begin
      csum <= '0;
      err  <= 1'b0;
    end else begin
      if (accept) csum <= csum ^ bus.i_dat;
      if ((state == SELECT) && last_bank) err <= (csum != bus.i_csum);
    end
  end
`else
  logic unused_csum;
  assign unused_csum = ^{bus.i_csum, start_load, accept};
  assign err         = 1'b0;
`endif

  assign bus.o_rdy    = (state == WRITE);
  assign bus.o_ram_d  = ram_d;
  assign bus.o_ram_we = ram_we;
  assign bus.o_ram_se = ram_se;
  assign bus.o_busy   = busy;
  assign bus.o_done   = done;
  assign bus.o_err    = err;

endmodule

`default_nettype wire

// File: tb/tb_accum_mult_ram_loader.sv
// ---------------------------------------------------------------------------
// tb_accum_mult_ram_loader: table, hand-written and random loads checked
// against a stream model of the expected write/select strobes. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_accum_mult_ram_loader;

  localparam int RAM_A_W  = 2;
  localparam int RAM_D_W  = 32;
  localparam int NUM_RAMS = 2;
  localparam int DEPTH    = 4;
  localparam int NW       = DEPTH * NUM_RAMS;

`ifdef ACCUM_RAM_LOADER_CSUM_EN
  localparam logic CE = 1'b1;
`else
  localparam logic CE = 1'b0;
`endif

  typedef logic [31:0] words_t [NW];
  typedef struct packed {logic se; logic [31:0] d;} ev_t;
  typedef struct packed {
    logic [NW-1:0][31:0] w;
    logic [31:0]         csum;
    logic [3:0]          gap;
    logic                mid;
    logic                exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  accum_mult_ram_loader_if #(.RAM_D_W(RAM_D_W)) bus ();

  accum_mult_ram_loader #(
    .RAM_A_W (RAM_A_W),
    .RAM_D_W (RAM_D_W),
    .NUM_RAMS(NUM_RAMS)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int  compared   = 0;
  int  mismatched = 0;
  int  overlap    = 0;
  ev_t evq[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_ram_we) evq.push_back({1'b0, bus.o_ram_d});
      if (bus.o_ram_se) evq.push_back({1'b1, 32'h0});
      if (bus.o_ram_we && bus.o_ram_se) overlap++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: each bank is DEPTH writes in input order followed by one select.
  task automatic check_stream(input string name, input words_t w);
    ev_t exp[$];
    for (int b = 0; b < NUM_RAMS; b++) begin
      for (int i = 0; i < DEPTH; i++) exp.push_back({1'b0, w[b*DEPTH+i]});
      exp.push_back({1'b1, 32'h0});
    end
    chk($sformatf("%s event count", name), evq.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < evq.size()) chk($sformatf("%s event %0d", name, i), evq[i], exp[i]);
  endtask

  function automatic logic [31:0] xor_all(input words_t w);
    logic [31:0] x = 32'h0;
    for (int i = 0; i < NW; i++) x ^= w[i];
    return x;
  endfunction

  task automatic send_word(input logic [31:0] w, input int gap_max, input logic mid);
    logic hs;
    bit   ok = 1'b0;
    repeat ($urandom_range(0, gap_max)) begin
      bus.i_val = 1'b0;
      cyc(1);
    end
    bus.i_val   = 1'b1;
    bus.i_dat   = w;
    bus.i_start = mid && ($urandom_range(0, 2) == 0);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      hs = bus.o_rdy;
      @(posedge clk);
      #1;
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
    bus.i_start = 1'b0;
    bus.i_val   = 1'b0;
    if (!ok) chk("handshake timeout", 0, 1);
  endtask

  task automatic run_load(input string name, input words_t w, input logic [31:0] csum,
                          input int gap_max, input logic mid, input logic exp_err);
    evq.delete();
    bus.i_csum  = csum;
    bus.i_start = 1'b1;
    cyc(1);
    bus.i_start = 1'b0;
    @(negedge clk);
    chk({name, " busy after start"}, bus.o_busy, 1);
    chk({name, " rdy after start"}, bus.o_rdy, 1);
    chk({name, " done cleared"}, bus.o_done, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < NW; i++) send_word(w[i], gap_max, mid);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.o_done) break;
    end
    chk({name, " done"}, bus.o_done, 1);
    cyc(2);
    @(negedge clk);
    check_stream(name, w);
    chk({name, " err"}, bus.o_err, exp_err);
    chk({name, " busy idle"}, bus.o_busy, 0);
    chk({name, " rdy idle"}, bus.o_rdy, 0);
    @(posedge clk);
    #1;
  endtask

  vec_t   vecs[5];
  words_t wv;
  int     exp_rdy[11]  = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0};
  int     exp_done[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < NW; i++) vecs[r].w[i] = 32'(i + 1);
      vecs[r].gap = 4'd0; vecs[r].mid = 1'b0;
    end
    vecs[0].csum = 32'h8;  vecs[0].gap = 4'd1; vecs[0].exp_err = 1'b0;
    vecs[1].csum = 32'h9;  vecs[1].mid = 1'b1; vecs[1].exp_err = CE;
    for (int i = 0; i < NW; i++) vecs[2].w[i] = 32'hFFFF_FFFF;
    vecs[2].csum = 32'h0;  vecs[2].gap = 4'd2; vecs[2].exp_err = 1'b0;
    for (int i = 0; i < NW; i++) vecs[3].w[i] = 32'((i + 1) * 16);
    vecs[3].csum = 32'h80; vecs[3].gap = 4'd1; vecs[3].mid = 1'b1; vecs[3].exp_err = 1'b0;
    for (int i = 0; i < NW; i++) vecs[4].w[i] = 32'((i + 1) * 16);
    vecs[4].csum = 32'h0;  vecs[4].exp_err = CE;

    bus.i_start = 1'b0; bus.i_val = 1'b0; bus.i_dat = '0; bus.i_csum = '0;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset rdy", bus.o_rdy, 0);
    chk("reset we", bus.o_ram_we, 0);
    chk("reset se", bus.o_ram_se, 0);
    chk("reset busy", bus.o_busy, 0);
    chk("reset done", bus.o_done, 0);
    chk("reset err", bus.o_err, 0);
    chk("reset ram_d", bus.o_ram_d, 0);

    // Back-to-back stream 1..8 with val held high, including in SELECT/DONE.
    @(posedge clk);
    #1;
    evq.delete();
    bus.i_csum  = 32'h8;
    bus.i_start = 1'b1;
    cyc(1);
    bus.i_start = 1'b0;
    bus.i_val   = 1'b1;
    bus.i_dat   = 32'h1;
    for (int c = 0; c < 11; c++) begin
      logic hs;
      @(negedge clk);
      hs = bus.o_rdy;
      chk($sformatf("stream rdy cycle %0d", c + 1), bus.o_rdy, exp_rdy[c]);
      chk($sformatf("stream done cycle %0d", c + 1), bus.o_done, exp_done[c]);
      @(posedge clk);
      #1;
      if (hs) bus.i_dat = bus.i_dat + 32'h1;
    end
    cyc(4);
    @(negedge clk);
    for (int i = 0; i < NW; i++) wv[i] = 32'(i + 1);
    check_stream("stream", wv);
    chk("stream done held", bus.o_done, 1);
    chk("stream err", bus.o_err, 0);
    @(posedge clk);
    #1;
    bus.i_val = 1'b0;

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < NW; i++) wv[i] = vecs[r].w[i];
      run_load($sformatf("vec%0d", r), wv, vecs[r].csum, int'(vecs[r].gap), vecs[r].mid,
               vecs[r].exp_err);
    end

    // Reset part-way through bank 0.
    evq.delete();
    bus.i_start = 1'b1;
    cyc(1);
    bus.i_start = 1'b0;
    for (int i = 0; i < 3; i++) send_word(32'(i + 1), 0, 1'b0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    @(negedge clk);
    chk("midreset we", bus.o_ram_we, 0);
    chk("midreset se", bus.o_ram_se, 0);
    chk("midreset busy", bus.o_busy, 0);
    chk("midreset done", bus.o_done, 0);
    chk("midreset rdy", bus.o_rdy, 0);
    chk("midreset ram_d", bus.o_ram_d, 0);
    evq.delete();
    bus.i_val = 1'b1;
    cyc(5);
    bus.i_val = 1'b0;
    chk("midreset no strobes", evq.size(), 0);
    for (int i = 0; i < NW; i++) wv[i] = 32'(i + 1);
    run_load("after reset", wv, 32'h8, 1, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      logic [31:0] cs;
      for (int i = 0; i < NW; i++) wv[i] = $urandom;
      cs = xor_all(wv);
      if ($urandom_range(0, 1) == 1) cs ^= (32'h1 << $urandom_range(0, 31));
      run_load($sformatf("rand%0d", r), wv, cs, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               CE && (cs != xor_all(wv)));
    end

    chk("we/se overlap cycles", overlap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1);
  end

endmodule

`default_nettype wire
